// File: rtl/sumador_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
package sumador_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Requester-ID width; at least one bit so ports never collapse to zero width.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sumador_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after the
// pointer, searching cyclically.
module sumador_rr_arbiter
  import sumador_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]           i_req,
  input  logic [id_w(NREQ)-1:0]     i_rr_ptr,
  output logic [NREQ-1:0]           o_grant_oh_c,
  output logic [id_w(NREQ)-1:0]     o_grant_idx_c,
  output logic                      o_any_valid_c
);

  localparam int unsigned IDW = id_w(NREQ);

  logic [IDW-1:0] w_idx;

  always_comb begin
    o_grant_oh_c  = '0;
    o_grant_idx_c = '0;
    o_any_valid_c = 1'b0;
    w_idx         = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = IDW'((32'(i_rr_ptr) + i) % NREQ);
      if (!o_any_valid_c && i_req[w_idx]) begin
        o_any_valid_c        = 1'b1;
        o_grant_idx_c        = w_idx;
        o_grant_oh_c[w_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sumador_rr_sched.sv
// Round-robin scheduler sharing one external combinational adder among NREQ
// requesters. Optional completion counter enabled by SUMADOR_SCHED_STATS_EN.
module sumador_rr_sched
  import sumador_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [id_w(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic [CNT_W-1:0]        ops_count
);

  localparam int unsigned IDW = id_w(NREQ);

  sched_state_t   r_state, w_state_nxt;
  logic [IDW-1:0] r_rr_ptr, r_id, r_rsp_id, w_grant_idx;
  logic [NREQ-1:0] w_grant_oh;
  logic           w_any_valid, w_accept, w_done;
  logic [WIDTH-1:0] r_add_a, r_add_b, r_rsp_sum;
  logic           r_rsp_valid, r_rsp_cout;
  logic [WIDTH-1:0] w_a_sl [NREQ];
  logic [WIDTH-1:0] w_b_sl [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_a_sl[g] = req_a[g*WIDTH +: WIDTH];
    assign w_b_sl[g] = req_b[g*WIDTH +: WIDTH];
  end

  sumador_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req         (req_valid),
    .i_rr_ptr      (r_rr_ptr),
    .o_grant_oh_c  (w_grant_oh),
    .o_grant_idx_c (w_grant_idx),
    .o_any_valid_c (w_any_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and the same-cycle request handshake.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid && !rst) begin
          req_ready   = w_grant_oh;
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Adder operands live only for the EXEC cycle; result captured at its end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_id        <= '0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_add_a <= w_a_sl[w_grant_idx];
        r_add_b <= w_b_sl[w_grant_idx];
        r_id    <= w_grant_idx;
      end else if (r_state == EXEC) begin
        r_add_a     <= '0;
        r_add_b     <= '0;
        r_rsp_sum   <= add_sum;
        r_rsp_cout  <= add_cout;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b0;
        r_rr_ptr    <= IDW'((32'(r_id) + 32'd1) % NREQ);
      end
    end
  end

  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_id    = r_rsp_id;

`ifdef SUMADOR_SCHED_STATS_EN
  logic [CNT_W-1:0] r_ops_count;

  always_ff @(posedge clk) begin
    if (rst)         r_ops_count <= '0;
    else if (w_done) r_ops_count <= r_ops_count + CNT_W'(1);
  end

  assign ops_count = r_ops_count;
`else
  assign ops_count = '0;
`endif

endmodule

// File: tb/tb_sumador_rr_sched.sv
// Scoreboard bench for sumador_rr_sched; the bench models the shared adder.
module tb_sumador_rr_sched;
  import sumador_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 8;

  typedef struct packed {
    logic [0:0]   id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      add_a, add_b, add_sum;
  logic              add_cout;
  logic              rsp_valid, rsp_ready, rsp_cout;
  logic [0:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic [15:0]       ops_count;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   log_id[$];
  int   log_cyc[$];
  int   cyc = 0;
  int   n_done = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  sumador_rr_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .ops_count(ops_count)
  );

  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return '{id: 1'(id), sum: s[W-1:0], cout: s[W]};
  endfunction

  // Record every request handshake and completed response.
  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(model(i, req_a[i*W +: W], req_b[i*W +: W]));
          acc_cyc.push_back(cyc);
          log_id.push_back(i);
          log_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) n_done <= n_done + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      #1;
      if (req_ready[id] === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic await_rsp(output exp_t got, output int at_cyc);
    got = 'x;
    at_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        got = '{id: rsp_id, sum: rsp_sum, cout: rsp_cout};
        at_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic pop_exp(output exp_t e, output int acc);
    e = 'x;
    acc = -100;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (acc_cyc.size() > 0) acc = acc_cyc.pop_front();
  endtask

  task automatic test_reset();
    exp_t got, e;
    int at, acc;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_a = {8'h0A, 8'h21};
    req_b = {8'h0B, 8'h43};
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({req_ready, rsp_valid} !== 3'b000) $display("FAIL reset_hs: got %b expected 000", {req_ready, rsp_valid});
    else n_pass++;
    n_total++;
    if ({rsp_id, rsp_sum, rsp_cout, add_a, add_b, ops_count} !== '0)
      $display("FAIL reset_data: id=%h sum=%h cout=%b a=%h b=%h cnt=%h expected all 0",
               rsp_id, rsp_sum, rsp_cout, add_a, add_b, ops_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL reset_first_grant: got %b expected 01", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 2'b00;
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e) $display("FAIL reset_rsp: got %h expected %h", got, e);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    exp_t got, e;
    int at, acc;
    bit ok;
    issue(0, 8'h12, 8'h34, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL single_ready: got %b expected 1", ok);
    else n_pass++;
    #1;
    n_total++;
    if ({add_a, add_b} !== 16'h1234) $display("FAIL single_exec_ops: got %h expected 1234", {add_a, add_b});
    else n_pass++;
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e || got.sum !== 8'h46) $display("FAIL single_rsp: got %h expected %h", got, e);
    else n_pass++;
    n_total++;
    if (at - acc !== 2) $display("FAIL single_latency: got %0d expected 2", at - acc);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_valid_drop: got %b expected 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_carry();
    exp_t got, e;
    int at, acc;
    bit ok;
    issue(0, 8'h80, 8'h80, ok);
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e || {got.sum, got.cout} !== 9'h001) $display("FAIL carry_80: got %h expected %h", got, e);
    else n_pass++;
    @(negedge clk);
    issue(1, 8'hFF, 8'h01, ok);
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e || got !== exp_t'({1'b1, 8'h00, 1'b1})) $display("FAIL carry_ff: got %h expected %h", got, e);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    exp_t got, e;
    int at, acc, base, nrsp, gid, gdt;
    base = log_id.size();
    nrsp = 0;
    req_a = {8'h10, 8'h01};
    req_b = {8'h20, 8'h02};
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 60 && nrsp < 4; k++) begin
      @(negedge clk);
      #1;
      if (log_id.size() - base >= 4) req_valid = 2'b00;
      if (rsp_valid === 1'b1) begin
        got = '{id: rsp_id, sum: rsp_sum, cout: rsp_cout};
        pop_exp(e, acc);
        nrsp++;
        n_total++;
        if (got !== e) $display("FAIL fair_rsp%0d: got %h expected %h", nrsp, got, e);
        else n_pass++;
      end
    end
    req_valid = 2'b00;
    for (int j = 0; j < 4; j++) begin
      gid = (base + j < log_id.size()) ? log_id[base + j] : -1;
      n_total++;
      if (gid !== j % 2) $display("FAIL fair_order%0d: got %0d expected %0d", j, gid, j % 2);
      else n_pass++;
      if (j > 0) begin
        gdt = (base + j < log_cyc.size()) ? log_cyc[base + j] - log_cyc[base + j - 1] : -1;
        n_total++;
        if (gdt !== 3) $display("FAIL fair_interval%0d: got %0d expected 3", j, gdt);
        else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_stall();
    exp_t got, e;
    int at, acc, exp_cnt;
    bit ok;
    rsp_ready = 1'b0;
    issue(1, 8'h3C, 8'h0F, ok);
    await_rsp(got, at);
    req_a[7:0] = 8'h07;
    req_b[7:0] = 8'h09;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_total++;
      if (rsp_valid !== 1'b1 || exp_q.size() == 0 || rsp_sum !== exp_q[0].sum || req_ready !== 2'b00)
        $display("FAIL stall_hold%0d: valid=%b sum=%h ready=%b expected 1/4b/00", k, rsp_valid, rsp_sum, req_ready);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e || got.sum !== 8'h4B) $display("FAIL stall_rsp: got %h expected %h", got, e);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL stall_next_grant: got %b expected 01", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 2'b00;
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e || got.sum !== 8'h10) $display("FAIL stall_next_rsp: got %h expected %h", got, e);
    else n_pass++;
    @(negedge clk);
    #1;
`ifdef SUMADOR_SCHED_STATS_EN
    exp_cnt = n_done;
`else
    exp_cnt = 0;
`endif
    n_total++;
    if (ops_count !== 16'(exp_cnt)) $display("FAIL ops_count: got %0d expected %0d", ops_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    exp_t got, e;
    int at, acc, bad;
    bit ok;
    rsp_ready = 1'b1;
    issue(1, 8'h01, 8'h02, ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acc_cyc.delete();
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_total++;
    if (bad !== 0) $display("FAIL midop_no_rsp: got %0d valid cycles expected 0", bad);
    else n_pass++;
    n_total++;
    if (ops_count !== 16'h0000) $display("FAIL midop_count: got %h expected 0000", ops_count);
    else n_pass++;
    req_a = {8'h22, 8'h05};
    req_b = {8'h33, 8'h06};
    req_valid = 2'b11;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL midop_ptr_reset: got %b expected 01", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 2'b00;
    await_rsp(got, at);
    pop_exp(e, acc);
    n_total++;
    if (got !== e || got.sum !== 8'h0B) $display("FAIL midop_after_rsp: got %h expected %h", got, e);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_carry();
    test_fairness();
    test_back_to_back_stall();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
